// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the pipeline.
// Owns the architectural PC and keeps at most one request outstanding to
// instruction memory. Data from memory is either passed straight through
// (zero-wait streaming) or parked in a buffer while decode stalls. A
// redirect that lands while a request is in flight lets that request
// complete, drops its data, and then refetches from the new PC.
//
// Handshake: o_IMemReq/o_IMemAddr stay asserted and stable until a cycle
// with i_IMemReady=1 completes the request. i_IMemRData is sampled only in
// that cycle. Requests are never withdrawn, except by reset.
//
// Optional build macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a request start at a PC with nonzero low bits enters a TRAP
//               state, which raises o_MisalignF until a redirect arrives.
//   undefined : the low two address bits are masked off and o_MisalignF is 0.
module fetch_stage #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       INSTR_WIDTH   = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     i_n_EN,
    input  logic                     i_PCSrcD,
    input  logic [ADDRESS_WIDTH-1:0] i_PCBranchD,
    input  logic                     i_JumpD,
    input  logic [ADDRESS_WIDTH-1:0] i_PCJumpD,
    output logic                     o_IMemReq,
    output logic [ADDRESS_WIDTH-1:0] o_IMemAddr,
    input  logic                     i_IMemReady,
    input  logic [INSTR_WIDTH-1:0]   i_IMemRData,
    output logic [INSTR_WIDTH-1:0]   o_InstrF,
    output logic [ADDRESS_WIDTH-1:0] o_PCPlus4F,
    output logic [4:0]               o_ShamtF,
    output logic                     o_ValidF,
    output logic                     o_FetchBusy,
    output logic                     o_MisalignF
);

    // S_IDLE    : one cycle after reset before the first request
    // S_FETCH   : request outstanding; its data is wanted
    // S_HOLD    : instruction buffered while decode stalls; no request
    // S_DISCARD : request outstanding but a redirect made its data stale
    // S_TRAP    : misaligned PC, waiting for a redirect (trap build only)
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_HOLD    = 3'd2,
        S_DISCARD = 3'd3,
        S_TRAP    = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [ADDRESS_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [INSTR_WIDTH-1:0]   instr_buf_q, instr_buf_d;

    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic [ADDRESS_WIDTH-1:0] redirect_tgt;
    logic [ADDRESS_WIDTH-1:0] next_pc;
    logic                     redirect_take;
    logic                     start_req;
    logic [ADDRESS_WIDTH-1:0] start_pc;
    logic [INSTR_WIDTH-1:0]   instr_f;
    logic                     misalign_f;

    // Next-PC selection: jump beats branch beats sequential; redirects only
    // count on an enabled (i_n_EN=0) edge.
    always_comb begin
        pc_plus4      = pc_q + ADDRESS_WIDTH'(4);
        redirect_tgt  = i_JumpD ? i_PCJumpD : i_PCBranchD;
        next_pc       = (i_JumpD || i_PCSrcD) ? redirect_tgt : pc_plus4;
        redirect_take = (i_JumpD || i_PCSrcD) && !i_n_EN;
    end

    // FSM next state, datapath next values and decoded outputs.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        instr_buf_d = instr_buf_q;
        start_req   = 1'b0;
        start_pc    = pc_q;
        o_IMemReq   = 1'b0;
        instr_f     = '0;
        o_ValidF    = 1'b0;
        o_FetchBusy = 1'b1;
        misalign_f  = 1'b0;

        case (state_q)
            S_IDLE: begin
                start_req = 1'b1;
                start_pc  = pc_q;
            end
            S_FETCH: begin
                o_IMemReq = 1'b1;
                if (i_IMemReady) begin
                    instr_f     = i_IMemRData;
                    o_ValidF    = 1'b1;
                    o_FetchBusy = 1'b0;
                    if (!i_n_EN) begin
                        pc_d      = next_pc;
                        start_req = 1'b1;
                        start_pc  = next_pc;
                    end else begin
                        instr_buf_d = i_IMemRData;
                        state_d     = S_HOLD;
                    end
                end else if (redirect_take) begin
                    pc_d    = redirect_tgt;
                    state_d = S_DISCARD;
                end
            end
            S_HOLD: begin
                instr_f     = instr_buf_q;
                o_ValidF    = 1'b1;
                o_FetchBusy = 1'b0;
                if (!i_n_EN) begin
                    pc_d      = next_pc;
                    start_req = 1'b1;
                    start_pc  = next_pc;
                end
            end
            S_DISCARD: begin
                // The stale request stays on the bus until memory answers.
                o_IMemReq = 1'b1;
                if (redirect_take) begin
                    pc_d = redirect_tgt;
                end
                if (i_IMemReady) begin
                    start_req = 1'b1;
                    start_pc  = redirect_take ? redirect_tgt : pc_q;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            S_TRAP: begin
                misalign_f = 1'b1;
                if (redirect_take) begin
                    pc_d      = redirect_tgt;
                    start_req = 1'b1;
                    start_pc  = redirect_tgt;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Common request launch: latch the address and enter FETCH (or TRAP).
        if (start_req) begin
            state_d = S_FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
            req_addr_d = start_pc;
            if (start_pc[1:0] != 2'b00) begin
                state_d = S_TRAP;
            end
`else
            req_addr_d = start_pc & ~ADDRESS_WIDTH'(3);
`endif
        end
    end

    // State and datapath registers; reset abandons any in-flight request.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            instr_buf_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            instr_buf_q <= instr_buf_d;
        end
    end

    // Output wiring; shamt is always a slice of the presented instruction.
    always_comb begin
        o_IMemAddr  = req_addr_q;
        o_InstrF    = instr_f;
        o_ShamtF    = instr_f[10:6];
        o_PCPlus4F  = pc_plus4;
        o_MisalignF = misalign_f;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a randomized run checked against a
// transaction-level model of the fetch stage.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        n_en;
    logic        pcsrc;
    logic [31:0] pcb;
    logic        jump;
    logic [31:0] pcj;
    logic        ready;
    logic [31:0] rdata;

    logic        req,   w_req;
    logic [31:0] addr,  w_addr;
    logic [31:0] instr, w_instr;
    logic [31:0] pcp4,  w_pcp4;
    logic [4:0]  shamt, w_shamt;
    logic        valid, w_valid;
    logic        busy,  w_busy;
    logic        mis,   w_mis;

    int n_checks;
    int n_pass;

    fetch_stage #(.ADDRESS_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0)) dut (
        .i_CLK(clk), .i_RST(rst), .i_n_EN(n_en),
        .i_PCSrcD(pcsrc), .i_PCBranchD(pcb), .i_JumpD(jump), .i_PCJumpD(pcj),
        .o_IMemReq(req), .o_IMemAddr(addr), .i_IMemReady(ready), .i_IMemRData(rdata),
        .o_InstrF(instr), .o_PCPlus4F(pcp4), .o_ShamtF(shamt), .o_ValidF(valid),
        .o_FetchBusy(busy), .o_MisalignF(mis)
    );

    fetch_stage #(.ADDRESS_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .i_CLK(clk), .i_RST(rst), .i_n_EN(n_en),
        .i_PCSrcD(pcsrc), .i_PCBranchD(pcb), .i_JumpD(jump), .i_PCJumpD(pcj),
        .o_IMemReq(w_req), .o_IMemAddr(w_addr), .i_IMemReady(ready), .i_IMemRData(rdata),
        .o_InstrF(w_instr), .o_PCPlus4F(w_pcp4), .o_ShamtF(w_shamt), .o_ValidF(w_valid),
        .o_FetchBusy(w_busy), .o_MisalignF(w_mis)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        n_en  = 1'b0;
        pcsrc = 1'b0;
        pcb   = 32'h0;
        jump  = 1'b0;
        pcj   = 32'h0;
        ready = 1'b0;
        rdata = 32'h0;
    endtask

    // Leaves the DUT in IDLE, one cycle before its first request.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst   = 1'b1;
        ready = 1'b1;
        rdata = 32'hFFFF_FFFF;
        #3;
        n_checks++; if (req !== 1'b0) $display("FAIL reset_req got %0b want 0", req); else n_pass++;
        n_checks++; if (instr !== 32'h0) $display("FAIL reset_instr got %h want 0", instr); else n_pass++;
        n_checks++; if (shamt !== 5'h0) $display("FAIL reset_shamt got %h want 0", shamt); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", valid); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL reset_busy got %0b want 1", busy); else n_pass++;
        n_checks++; if (mis !== 1'b0) $display("FAIL reset_misalign got %0b want 0", mis); else n_pass++;
        n_checks++; if (pcp4 !== 32'h4) $display("FAIL reset_pcplus4 got %h want 4", pcp4); else n_pass++;
        n_checks++; if (w_pcp4 !== 32'h0) $display("FAIL reset_wrap_pcplus4 got %h want 0", w_pcp4); else n_pass++;
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (req !== 1'b0) $display("FAIL idle_req got %0b want 0", req); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL idle_busy got %0b want 1", busy); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("FAIL idle_valid got %0b want 0", valid); else n_pass++;
    endtask

    // Zero-wait memory: one instruction per cycle at 0,4,8,C, then a
    // 3-cycle latency response at 0x10.
    task automatic test_stream_and_latency();
        logic [31:0] d;
        do_reset();
        ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            d     = $urandom();
            rdata = d;
            #1;
            n_checks++; if (addr !== 32'(4 * k)) $display("FAIL stream_addr[%0d] got %h want %h", k, addr, 32'(4 * k)); else n_pass++;
            n_checks++; if (instr !== d || valid !== 1'b1) $display("FAIL stream_instr[%0d] got %h/%0b want %h/1", k, instr, valid, d); else n_pass++;
            n_checks++; if (pcp4 !== 32'(4 * k + 4)) $display("FAIL stream_pcplus4[%0d] got %h want %h", k, pcp4, 32'(4 * k + 4)); else n_pass++;
            tick();
        end
        ready = 1'b0;
        rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++; if (req !== 1'b1 || addr !== 32'h10) $display("FAIL wait_req[%0d] got %0b/%h want 1/10", k, req, addr); else n_pass++;
            n_checks++; if (busy !== 1'b1 || instr !== 32'h0) $display("FAIL wait_busy[%0d] got %0b/%h want 1/0", k, busy, instr); else n_pass++;
            tick();
        end
        ready = 1'b1;
        rdata = 32'h0002_1080;
        #1;
        n_checks++; if (instr !== 32'h0002_1080) $display("FAIL latency_instr got %h want 00021080", instr); else n_pass++;
        n_checks++; if (shamt !== 5'd2) $display("FAIL latency_shamt got %0d want 2", shamt); else n_pass++;
        n_checks++; if (busy !== 1'b0 || valid !== 1'b1) $display("FAIL latency_flags got %0b/%0b want 0/1", busy, valid); else n_pass++;
        tick();
        ready = 1'b0;
        #1;
        n_checks++; if (addr !== 32'h14 || req !== 1'b1) $display("FAIL latency_next got %0b/%h want 1/14", req, addr); else n_pass++;
    endtask

    // Stall on the response cycle: data parks in HOLD, then fetch resumes.
    task automatic test_hold();
        n_en  = 1'b1;
        ready = 1'b1;
        rdata = 32'hAABB_CCDD;
        #1;
        n_checks++; if (instr !== 32'hAABB_CCDD || valid !== 1'b1) $display("FAIL hold_capture got %h/%0b want aabbccdd/1", instr, valid); else n_pass++;
        tick();
        for (int k = 0; k < 2; k++) begin
            ready = 1'($urandom_range(0, 1));
            rdata = $urandom();
            n_en  = (k == 1) ? 1'b0 : 1'b1;
            #1;
            n_checks++; if (req !== 1'b0) $display("FAIL hold_req[%0d] got %0b want 0", k, req); else n_pass++;
            n_checks++; if (instr !== 32'hAABB_CCDD || valid !== 1'b1 || busy !== 1'b0) $display("FAIL hold_instr[%0d] got %h/%0b/%0b want aabbccdd/1/0", k, instr, valid, busy); else n_pass++;
            tick();
        end
        ready = 1'b0;
        #1;
        n_checks++; if (req !== 1'b1 || addr !== 32'h18) $display("FAIL hold_resume got %0b/%h want 1/18", req, addr); else n_pass++;
    endtask

    // Branch while a request is pending; jump priority; ignored redirect.
    task automatic test_redirect();
        do_reset();
        tick();
        ready = 1'b1;
        jump  = 1'b1;
        pcj   = 32'h20;
        tick();
        jump  = 1'b0;
        ready = 1'b0;
        pcsrc = 1'b1;
        pcb   = 32'h100;
        #1;
        n_checks++; if (req !== 1'b1 || addr !== 32'h20) $display("FAIL redir_pending got %0b/%h want 1/20", req, addr); else n_pass++;
        tick();
        pcsrc = 1'b0;
        #1;
        n_checks++; if (req !== 1'b1 || addr !== 32'h20 || valid !== 1'b0) $display("FAIL discard_hold got %0b/%h/%0b want 1/20/0", req, addr, valid); else n_pass++;
        tick();
        ready = 1'b1;
        rdata = 32'h1234_5678;
        #1;
        n_checks++; if (valid !== 1'b0 || instr !== 32'h0 || busy !== 1'b1) $display("FAIL discard_drop got %0b/%h/%0b want 0/0/1", valid, instr, busy); else n_pass++;
        tick();
        jump  = 1'b1;
        pcj   = 32'h300;
        pcsrc = 1'b1;
        pcb   = 32'h400;
        #1;
        n_checks++; if (req !== 1'b1 || addr !== 32'h100 || valid !== 1'b1) $display("FAIL redir_target got %0b/%h/%0b want 1/100/1", req, addr, valid); else n_pass++;
        tick();
        jump  = 1'b0;
        ready = 1'b0;
        n_en  = 1'b1;
        #1;
        n_checks++; if (addr !== 32'h300) $display("FAIL jump_priority got %h want 300", addr); else n_pass++;
        tick();
        pcsrc = 1'b0;
        n_en  = 1'b0;
        ready = 1'b1;
        #1;
        n_checks++; if (addr !== 32'h300 || req !== 1'b1) $display("FAIL redir_ignored got %0b/%h want 1/300", req, addr); else n_pass++;
        tick();
        ready = 1'b0;
        #1;
        n_checks++; if (addr !== 32'h304) $display("FAIL after_ignored got %h want 304", addr); else n_pass++;
    endtask

    // Address wrap from the top of memory; reset asserted mid-wait.
    task automatic test_wrap_and_midreset();
        do_reset();
        tick();
        ready = 1'b1;
        #1;
        n_checks++; if (w_addr !== 32'hFFFF_FFFC || w_req !== 1'b1) $display("FAIL wrap_first got %0b/%h want 1/fffffffc", w_req, w_addr); else n_pass++;
        n_checks++; if (w_pcp4 !== 32'h0) $display("FAIL wrap_pcplus4 got %h want 0", w_pcp4); else n_pass++;
        tick();
        ready = 1'b0;
        #1;
        n_checks++; if (w_addr !== 32'h0 || w_pcp4 !== 32'h4) $display("FAIL wrap_next got %h/%h want 0/4", w_addr, w_pcp4); else n_pass++;
        n_checks++; if (req !== 1'b1 || pcp4 !== 32'h8) $display("FAIL midreset_pre got %0b/%h want 1/8", req, pcp4); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (req !== 1'b0 || busy !== 1'b1 || valid !== 1'b0) $display("FAIL midreset_flags got %0b/%0b/%0b want 0/1/0", req, busy, valid); else n_pass++;
        n_checks++; if (pcp4 !== 32'h4 || w_pcp4 !== 32'h0) $display("FAIL midreset_pc got %h/%h want 4/0", pcp4, w_pcp4); else n_pass++;
        tick();
        rst = 1'b0;
    endtask

    // Branch to a misaligned target.
    task automatic test_misalign();
        do_reset();
        tick();
        ready = 1'b1;
        pcsrc = 1'b1;
        pcb   = 32'h102;
        tick();
        pcsrc = 1'b0;
        ready = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        n_checks++; if (mis !== 1'b1 || req !== 1'b0) $display("FAIL trap_enter got %0b/%0b want 1/0", mis, req); else n_pass++;
        n_checks++; if (busy !== 1'b1 || valid !== 1'b0) $display("FAIL trap_flags got %0b/%0b want 1/0", busy, valid); else n_pass++;
        tick();
        jump = 1'b1;
        pcj  = 32'h200;
        #1;
        n_checks++; if (mis !== 1'b1) $display("FAIL trap_stay got %0b want 1", mis); else n_pass++;
        tick();
        jump = 1'b0;
        #1;
        n_checks++; if (mis !== 1'b0 || req !== 1'b1 || addr !== 32'h200) $display("FAIL trap_exit got %0b/%0b/%h want 0/1/200", mis, req, addr); else n_pass++;
`else
        n_checks++; if (req !== 1'b1 || addr !== 32'h100) $display("FAIL misalign_mask got %0b/%h want 1/100", req, addr); else n_pass++;
        n_checks++; if (mis !== 1'b0) $display("FAIL misalign_flag got %0b want 0", mis); else n_pass++;
`endif
    endtask

    // Randomized run against a transaction-level model: the model tracks
    // the PC, the address of the outstanding request, whether its data is
    // still wanted, and an optional parked instruction.
    task automatic test_random();
        logic [31:0] m_pc, m_addr, m_hold_data, tgt, e_instr, r;
        logic        m_started, m_stale, m_hold, e_req, e_valid, e_busy, go, redir;
        do_reset();
        m_pc = 32'h0; m_addr = 32'h0; m_hold_data = 32'h0;
        m_started = 1'b0; m_stale = 1'b0; m_hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            n_en  = ($urandom_range(0, 3) == 0);
            ready = ($urandom_range(0, 4) < 3);
            rdata = $urandom();
            jump  = ($urandom_range(0, 9) == 0);
            pcsrc = ($urandom_range(0, 7) == 0);
            r = $urandom(); pcj = {r[31:2], 2'b00};
            r = $urandom(); pcb = {r[31:2], 2'b00};
            #1;
            if (!m_started) begin
                e_req = 1'b0; e_instr = 32'h0; e_valid = 1'b0; e_busy = 1'b1;
            end else if (m_hold) begin
                e_req = 1'b0; e_instr = m_hold_data; e_valid = 1'b1; e_busy = 1'b0;
            end else if (!m_stale) begin
                e_req = 1'b1; e_instr = ready ? rdata : 32'h0; e_valid = ready; e_busy = !ready;
            end else begin
                e_req = 1'b1; e_instr = 32'h0; e_valid = 1'b0; e_busy = 1'b1;
            end
            n_checks++; if (req !== e_req) $display("FAIL rnd_req[%0d] got %0b want %0b", c, req, e_req); else n_pass++;
            if (e_req) begin
                n_checks++; if (addr !== m_addr) $display("FAIL rnd_addr[%0d] got %h want %h", c, addr, m_addr); else n_pass++;
            end
            n_checks++; if (instr !== e_instr) $display("FAIL rnd_instr[%0d] got %h want %h", c, instr, e_instr); else n_pass++;
            n_checks++; if (shamt !== e_instr[10:6]) $display("FAIL rnd_shamt[%0d] got %h want %h", c, shamt, e_instr[10:6]); else n_pass++;
            n_checks++; if (valid !== e_valid || busy !== e_busy) $display("FAIL rnd_flags[%0d] got %0b/%0b want %0b/%0b", c, valid, busy, e_valid, e_busy); else n_pass++;
            n_checks++; if (pcp4 !== m_pc + 32'd4) $display("FAIL rnd_pcplus4[%0d] got %h want %h", c, pcp4, m_pc + 32'd4); else n_pass++;
            n_checks++; if (mis !== 1'b0) $display("FAIL rnd_misalign[%0d] got %0b want 0", c, mis); else n_pass++;

            go    = !n_en;
            redir = (jump || pcsrc) && go;
            tgt   = jump ? pcj : (pcsrc ? pcb : m_pc + 32'd4);
            if (!m_started) begin
                m_started = 1'b1;
                m_addr    = m_pc;
            end else if (m_hold) begin
                if (go) begin
                    m_pc = tgt; m_addr = tgt; m_hold = 1'b0;
                end
            end else if (!m_stale) begin
                if (ready) begin
                    if (go) begin
                        m_pc = tgt; m_addr = tgt;
                    end else begin
                        m_hold = 1'b1; m_hold_data = rdata;
                    end
                end else if (redir) begin
                    m_pc = tgt; m_stale = 1'b1;
                end
            end else begin
                if (redir) m_pc = tgt;
                if (ready) begin
                    m_stale = 1'b0; m_addr = m_pc;
                end
            end
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clear_inputs();
        rst = 1'b1;
        tick();
        test_reset();
        test_stream_and_latency();
        test_hold();
        test_redirect();
        test_wrap_and_midreset();
        test_misalign();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
